// File: rtl/object_alloc_unit_if.sv
// rtl/object_alloc_unit_if.sv - command/result bundle of the object allocation unit
//
// Purpose: groups the command pulses from the matrix unit and the results
// returned to the matrix, video-memory and clipping units.
// Ports (master = command source, slave = object_alloc_unit):
//   crt_obj, del_obj, del_all, ref_addr : one-cycle command pulses
//   obj_num        : object number for del_obj / ref_addr
//   changed_in     : scene-changed level from the matrix unit
//   addr/addr_vld  : memory slot result of create or reference
//   lst_stored_obj/lst_stored_obj_vld : object number of the last create
//   obj_mem_full   : all slots in use
//   obj_map        : slot occupancy map
//   changed_out    : changed_in delayed by one cycle

interface object_alloc_unit_if #(
  parameter int NUM_OBJ = 32,
  parameter int AW      = 5
);
  logic               crt_obj;
  logic               del_obj;
  logic               del_all;
  logic               ref_addr;
  logic [AW-1:0]      obj_num;
  logic               changed_in;
  logic [AW-1:0]      addr;
  logic               addr_vld;
  logic [AW-1:0]      lst_stored_obj;
  logic               lst_stored_obj_vld;
  logic               obj_mem_full;
  logic [NUM_OBJ-1:0] obj_map;
  logic               changed_out;

  modport master (
    output crt_obj, del_obj, del_all, ref_addr, obj_num, changed_in,
    input  addr, addr_vld, lst_stored_obj, lst_stored_obj_vld,
           obj_mem_full, obj_map, changed_out
  );

  modport slave (
    input  crt_obj, del_obj, del_all, ref_addr, obj_num, changed_in,
    output addr, addr_vld, lst_stored_obj, lst_stored_obj_vld,
           obj_mem_full, obj_map, changed_out
  );
endinterface

// File: rtl/object_alloc_unit.sv
// rtl/object_alloc_unit.sv - object number / memory slot allocator with address lookup
//
// Purpose: allocates and frees object numbers and video-memory slots,
// translates object numbers to slot addresses and publishes the slot map.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : object_alloc_unit_if.slave (commands in, results out)

module object_alloc_unit #(
  parameter int NUM_OBJ = 32,
  parameter int AW      = 5
) (
  input  logic               clk,
  input  logic               rst,
  object_alloc_unit_if.slave bus
);

  logic [NUM_OBJ-1:0] obj_used;
  logic [NUM_OBJ-1:0] obj_map_q;
  logic [AW-1:0]      addr_tbl [NUM_OBJ];
  logic [AW-1:0]      addr_q;
  logic               addr_vld_q;
  logic [AW-1:0]      lst_q;
  logic               lst_vld_q;
  logic               full_q;
  logic               changed_q;

  logic [NUM_OBJ-1:0] used_nxt;
  logic [NUM_OBJ-1:0] map_nxt;
  logic [AW-1:0]      addr_nxt;
  logic               addr_vld_nxt;
  logic [AW-1:0]      lst_nxt;
  logic               lst_vld_nxt;
  logic               tbl_we;
  logic [AW-1:0]      free_n;
  logic [AW-1:0]      free_s;
  logic               found_n;
  logic               found_s;

  // Lowest free object number and lowest free slot.
  always_comb begin
    free_n  = '0;
    free_s  = '0;
    found_n = 1'b0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!found_n && !obj_used[i]) begin
        free_n  = AW'(i);
        found_n = 1'b1;
      end
      if (!found_s && !obj_map_q[i]) begin
        free_s  = AW'(i);
        found_s = 1'b1;
      end
    end
  end

  // Command decode; only the highest-priority pulse takes effect.
  always_comb begin
    used_nxt     = obj_used;
    map_nxt      = obj_map_q;
    addr_nxt     = addr_q;
    addr_vld_nxt = 1'b0;
    lst_nxt      = lst_q;
    lst_vld_nxt  = 1'b0;
    tbl_we       = 1'b0;
    if (bus.del_all) begin
      used_nxt = '0;
      map_nxt  = '0;
    end else if (bus.crt_obj) begin
      // Used numbers and occupied slots are always equal in count,
      // so a free number implies a free slot.
      if (!(&obj_used)) begin
        used_nxt[free_n] = 1'b1;
        map_nxt[free_s]  = 1'b1;
        tbl_we           = 1'b1;
        addr_nxt         = free_s;
        addr_vld_nxt     = 1'b1;
        lst_nxt          = free_n;
        lst_vld_nxt      = 1'b1;
      end
    end else if (bus.del_obj) begin
      if (obj_used[bus.obj_num]) begin
        used_nxt[bus.obj_num]          = 1'b0;
        map_nxt[addr_tbl[bus.obj_num]] = 1'b0;
      end
    end else if (bus.ref_addr) begin
      if (obj_used[bus.obj_num]) begin
        addr_nxt     = addr_tbl[bus.obj_num];
        addr_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obj_used   <= '0;
      obj_map_q  <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      lst_q      <= '0;
      lst_vld_q  <= 1'b0;
      full_q     <= 1'b0;
      changed_q  <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        addr_tbl[i] <= '0;
      end
    end else begin
      obj_used   <= used_nxt;
      obj_map_q  <= map_nxt;
      addr_q     <= addr_nxt;
      addr_vld_q <= addr_vld_nxt;
      lst_q      <= lst_nxt;
      lst_vld_q  <= lst_vld_nxt;
      // Full flag tracks the post-update occupancy, not the old one.
      full_q     <= &used_nxt;
      changed_q  <= bus.changed_in;
      if (tbl_we) begin
        addr_tbl[free_n] <= free_s;
      end
    end
  end

  assign bus.addr               = addr_q;
  assign bus.addr_vld           = addr_vld_q;
  assign bus.lst_stored_obj     = lst_q;
  assign bus.lst_stored_obj_vld = lst_vld_q;
  assign bus.obj_mem_full       = full_q;
  assign bus.obj_map            = obj_map_q;
  assign bus.changed_out        = changed_q;

endmodule

// File: tb/tb_object_alloc_unit.sv
// tb/tb_object_alloc_unit.sv - self-checking bench for object_alloc_unit

module tb_object_alloc_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  object_alloc_unit_if #(.NUM_OBJ(32), .AW(5)) bus ();

  object_alloc_unit #(.NUM_OBJ(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        avld;
    logic [4:0]  a;
    logic        lvld;
    logic [4:0]  l;
    logic [31:0] map;
    logic        full;
  } res_t;

  res_t q[$];
  res_t obs;
  res_t e;
  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_used = '0;
  logic [31:0] m_map  = '0;
  logic [4:0]  m_tbl [32];
  logic [4:0]  m_addr = '0;
  logic [4:0]  m_lst  = '0;

  task automatic model_step(input logic c, input logic d, input logic da,
                            input logic r, input logic [4:0] n, input logic rs);
    res_t x;
    int fn, fs;
    x.avld = 1'b0;
    x.lvld = 1'b0;
    if (rs) begin
      m_used = '0; m_map = '0; m_addr = '0; m_lst = '0;
    end else if (da) begin
      m_used = '0; m_map = '0;
    end else if (c) begin
      if (m_used != 32'hFFFF_FFFF) begin
        fn = 0; while (m_used[fn]) fn++;
        fs = 0; while (m_map[fs]) fs++;
        m_used[fn] = 1'b1;
        m_map[fs]  = 1'b1;
        m_tbl[fn]  = 5'(fs);
        m_addr = 5'(fs); m_lst = 5'(fn);
        x.avld = 1'b1; x.lvld = 1'b1;
      end
    end else if (d) begin
      if (m_used[n]) begin
        m_used[n] = 1'b0;
        m_map[m_tbl[n]] = 1'b0;
      end
    end else if (r) begin
      if (m_used[n]) begin
        m_addr = m_tbl[n];
        x.avld = 1'b1;
      end
    end
    x.a = m_addr;
    x.l = m_lst;
    x.map = m_map;
    x.full = (m_used == 32'hFFFF_FFFF);
    q.push_back(x);
  endtask

  // Drives one cycle of command pulses, records the expectation, and
  // captures the registered outputs just after the edge.
  task automatic issue(input logic c, input logic d, input logic da,
                       input logic r, input logic [4:0] n, input logic rs = 1'b0);
    @(negedge clk);
    bus.crt_obj = c; bus.del_obj = d; bus.del_all = da;
    bus.ref_addr = r; bus.obj_num = n; rst = rs;
    model_step(c, d, da, r, n, rs);
    @(posedge clk);
    #1;
    obs.avld = bus.addr_vld;
    obs.a    = bus.addr;
    obs.lvld = bus.lst_stored_obj_vld;
    obs.l    = bus.lst_stored_obj;
    obs.map  = bus.obj_map;
    obs.full = bus.obj_mem_full;
    bus.crt_obj = 1'b0; bus.del_obj = 1'b0; bus.del_all = 1'b0;
    bus.ref_addr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      issue(0, 0, 0, 0, 5'd0, 1'b1);
      e = q.pop_front();
      checks++;
      if (obs !== e || bus.changed_out !== 1'b0) begin
        failures++;
        $display("FAIL reset got=%h exp=%h chg=%b", obs, e, bus.changed_out);
      end
    end
  endtask

  task automatic test_create();
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 0, 5'd0);
      e = q.pop_front();
      checks++;
      if (obs !== e || obs.l !== 5'(i) || obs.a !== 5'(i)) begin
        failures++;
        $display("FAIL create%0d got=%h exp=%h", i, obs, e);
      end
      issue(0, 0, 0, 0, 5'd0);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL create_idle%0d got=%h exp=%h", i, obs, e);
      end
    end
    checks++;
    if (obs.map !== 32'h7 || obs.full !== 1'b0) begin
      failures++;
      $display("FAIL create_map got=%h/%b exp=7/0", obs.map, obs.full);
    end
  endtask

  task automatic test_delete();
    issue(0, 1, 0, 0, 5'd1);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.map !== 32'h5 || obs.avld !== 1'b0) begin
      failures++;
      $display("FAIL delete got=%h exp=%h", obs, e);
    end
    issue(1, 0, 0, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.l !== 5'd1 || obs.a !== 5'd1 || obs.map !== 32'h7) begin
      failures++;
      $display("FAIL reuse got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_ref();
    issue(0, 0, 0, 1, 5'd2);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.a !== 5'd2 || obs.avld !== 1'b1) begin
      failures++;
      $display("FAIL ref_used got=%h exp=%h", obs, e);
    end
    issue(0, 0, 0, 1, 5'd9);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.avld !== 1'b0) begin
      failures++;
      $display("FAIL ref_unused got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_full();
    issue(0, 0, 1, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL full_clear got=%h exp=%h", obs, e);
    end
    for (int i = 0; i < 32; i++) begin
      issue(1, 0, 0, 0, 5'd0);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL fill%0d got=%h exp=%h", i, obs, e);
      end
    end
    checks++;
    if (obs.full !== 1'b1 || obs.map !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL full_flag got=%b/%h exp=1/ffffffff", obs.full, obs.map);
    end
    issue(1, 0, 0, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.avld !== 1'b0 || obs.lvld !== 1'b0) begin
      failures++;
      $display("FAIL create_when_full got=%h exp=%h", obs, e);
    end
    issue(0, 1, 0, 0, 5'd5);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.full !== 1'b0) begin
      failures++;
      $display("FAIL del_from_full got=%h exp=%h", obs, e);
    end
    issue(1, 0, 0, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.l !== 5'd5 || obs.full !== 1'b1) begin
      failures++;
      $display("FAIL refill got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_priority();
    issue(1, 0, 1, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.map !== 32'h0 || obs.avld !== 1'b0 || obs.lvld !== 1'b0) begin
      failures++;
      $display("FAIL del_all_wins got=%h exp=%h", obs, e);
    end
    issue(1, 0, 0, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.l !== 5'd0 || obs.a !== 5'd0) begin
      failures++;
      $display("FAIL after_del_all got=%h exp=%h", obs, e);
    end
    // create beats del_obj and ref_addr in the same cycle
    issue(1, 1, 0, 1, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL create_wins got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_changed();
    logic exp_c;
    logic seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.changed_in = seq[i];
      exp_c = seq[i];
      @(posedge clk);
      #1;
      checks++;
      if (bus.changed_out !== exp_c) begin
        failures++;
        $display("FAIL changed%0d got=%b exp=%b", i, bus.changed_out, exp_c);
      end
    end
    bus.changed_in = 1'b0;
  endtask

  task automatic test_reset_during_create();
    issue(1, 0, 0, 0, 5'd0, 1'b1);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs !== '0 || bus.changed_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_create got=%h exp=%h", obs, e);
    end
    issue(1, 0, 0, 0, 5'd0);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.l !== 5'd0 || obs.map !== 32'h1) begin
      failures++;
      $display("FAIL post_rst_create got=%h exp=%h", obs, e);
    end
  endtask

  initial begin
    bus.crt_obj = 1'b0; bus.del_obj = 1'b0; bus.del_all = 1'b0;
    bus.ref_addr = 1'b0; bus.obj_num = '0; bus.changed_in = 1'b0;
    for (int i = 0; i < 32; i++) m_tbl[i] = '0;
    test_reset();
    test_create();
    test_delete();
    test_ref();
    test_full();
    test_priority();
    test_changed();
    test_reset_during_create();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/object_alloc_unit.md
Name: object_alloc_unit

Overview:
- Bookkeeping block for up to 32 graphics objects held in video memory.
- Allocates and frees object numbers and memory slots, and translates object numbers to memory addresses for the matrix unit.
- Publishes the slot-occupancy map and a registered "scene changed" flag to the clipping unit.
- Sits between matrix_unit_new (commands), video_mem_unit (address consumer) and clipping_unit (map/changed consumer).

Parameters:
- NUM_OBJ, 32, number of object numbers and memory slots (power of 2).
- AW, 5, width of object number and address (log2 NUM_OBJ).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- crt_obj  in  1  one-cycle pulse: allocate a new object.
- del_obj  in  1  one-cycle pulse: free object obj_num.
- del_all  in  1  one-cycle pulse: free every object.
- ref_addr  in  1  one-cycle pulse: look up memory address of obj_num.
- obj_num  in  AW  object number for del_obj and ref_addr.
- changed_in  in  1  scene-changed level from the matrix unit.
- addr  out  AW  memory address result for create or reference.
- addr_vld  out  1  one-cycle pulse qualifying addr.
- lst_stored_obj  out  AW  object number assigned by the last successful create.
- lst_stored_obj_vld  out  1  one-cycle pulse qualifying lst_stored_obj.
- obj_mem_full  out  1  high while all NUM_OBJ slots are in use.
- obj_map  out  NUM_OBJ  bit i = memory slot i holds a live object.
- changed_out  out  1  changed_in registered by one cycle.

Behaviour:
- State:
  - obj_used[31:0]: object number allocated.
  - obj_map[31:0]: memory slot occupied.
  - addr_tbl: 32 x AW map from object number to memory slot.
- Reset (rst=1 at posedge):
  - Clear obj_used, obj_map, addr_tbl.
  - addr=0, addr_vld=0, lst_stored_obj=0, lst_stored_obj_vld=0, changed_out=0.
  - obj_mem_full=0.
  - Any command in the same cycle as reset is ignored.
- Command priority when several pulses coincide: del_all > crt_obj > del_obj > ref_addr. Only the highest-priority command executes; the others are dropped.
- All results are registered, with a latency of 1 cycle. addr_vld and lst_stored_obj_vld are high exactly one cycle, the cycle after the command.
- crt_obj:
  - If not full:
    - Object number n = lowest index with obj_used=0.
    - Slot s = lowest index with obj_map=0.
    - Set obj_used[n] and obj_map[s]; write addr_tbl[n]=s.
    - Next cycle: addr=s, addr_vld=1, lst_stored_obj=n, lst_stored_obj_vld=1.
  - If full: no state change, both vld outputs stay 0, addr holds its previous value.
- del_obj:
  - If obj_used[obj_num]: clear obj_used[obj_num] and obj_map[addr_tbl[obj_num]].
  - addr_vld stays 0.
  - If the object does not exist: no effect.
- del_all: clear obj_used and obj_map in one cycle; addr_tbl contents become don't-care.
- ref_addr:
  - If obj_used[obj_num]: next cycle addr=addr_tbl[obj_num], addr_vld=1.
  - Otherwise addr_vld=0 and addr holds its previous value.
- obj_mem_full = AND of obj_used, registered, so it reflects the post-update state one cycle after the command. A create that fills the last slot succeeds, then full=1.
- changed_out <= changed_in every cycle; no other logic affects it.
- obj_map is a direct register output, updated on the same edge as allocation or free.
- Freed numbers and slots are reused lowest-first; indices do not wrap.

Test Plan:
- Reset, then 3 crt_obj pulses spaced by idle cycles -> lst_stored_obj 0,1,2 with addr 0,1,2, each vld for 1 cycle; obj_map=32'h7, full=0.
- From that state, del_obj obj_num=1 -> obj_map=32'h5. Then crt_obj -> lst_stored_obj=1, addr=1, obj_map=32'h7.
- ref_addr obj_num=2 -> addr=2, addr_vld=1 next cycle. ref_addr obj_num=9 (unused) -> addr_vld=0.
- 32 creates -> obj_mem_full=1 after the 32nd, obj_map=all ones. 33rd create -> no vld pulse, map unchanged. del_obj 5 -> full=0, next create returns lst_stored_obj=5.
- del_all together with crt_obj in the same cycle -> map=0, no vld pulse. A following create returns object 0 at addr 0.
- changed_in toggled 0->1->0 -> changed_out follows one cycle later. Assert rst during a create pulse -> all outputs 0 next cycle, nothing allocated.
